mult_div_unit: RTL and testbench

//  Multicycle signed MULT/DIV engine for the MIPS datapath. Consumes the A and B operand

---
 rtl/mult_div_unit_pkg.sv | 16 +
 rtl/mult_div_unit_booth_step.sv | 35 +++
 rtl/mult_div_unit.sv | 148 ++++++++++++++
 tb/tb_mult_div_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the multicycle MULT/DIV engine and the control unit that drives it.
// Pure declarations: no logic, no latency, no flow control.
// Backpressure: not applicable.
package mult_div_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/mult_div_unit_booth_step.sv
// One radix-2 Booth add/subtract and arithmetic right shift on {acc, q, q_m1}.
// Latency: combinational.
// Backpressure: none.
module booth_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] q,
    input  logic             q_m1,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   acc_nxt,
    output logic [WIDTH-1:0] q_nxt,
    output logic             q_m1_nxt
);

    // One guard bit keeps M = -2^(WIDTH-1) exact through the add/subtract.
    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] sum;

    assign m_ext = {m[WIDTH-1], m};

    always_comb begin
        sum = acc;
        case ({q[0], q_m1})
            2'b01:   sum = acc + m_ext;
            2'b10:   sum = acc - m_ext;
            default: sum = acc;
        endcase
    end

    assign acc_nxt  = {sum[WIDTH], sum[WIDTH:1]};
    assign q_nxt    = {sum[0], q[WIDTH-1:1]};
    assign q_m1_nxt = q[0];

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT (Booth) / DIV (restoring) engine writing the HI/LO pair.
// Latency: done one cycle after the 32nd iteration (33 edges after start); divide-by-zero 1 edge.
// Backpressure: start is accepted only in IDLE; it is dropped in MULT, DIV and DONE.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   acc;      // Booth accumulator, or divider remainder
    logic [WIDTH-1:0] qr;       // multiplier, or dividend shifting into quotient
    logic [WIDTH-1:0] mr;       // multiplicand, or divisor magnitude
    logic             qm1;
    logic             neg_q;
    logic             neg_r;
    logic             last;

    logic [WIDTH:0]   b_acc;
    logic [WIDTH-1:0] b_q;
    logic             b_qm1;

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   d_shift;
    logic [WIDTH:0]   d_diff;
    logic             d_ge;
    logic [WIDTH-1:0] d_rem;
    logic [WIDTH-1:0] d_quo;

    booth_step #(.WIDTH(WIDTH)) u_booth (
        .acc      (acc),
        .q        (qr),
        .q_m1     (qm1),
        .m        (mr),
        .acc_nxt  (b_acc),
        .q_nxt    (b_q),
        .q_m1_nxt (b_qm1)
    );

    // Magnitudes as unsigned: -2^(WIDTH-1) maps onto itself, which is the right unsigned value.
    assign abs_a = a_in[WIDTH-1] ? -a_in : a_in;
    assign abs_b = b_in[WIDTH-1] ? -b_in : b_in;

    assign d_shift = {acc[WIDTH-1:0], qr[WIDTH-1]};
    assign d_diff  = d_shift - {1'b0, mr};
    assign d_ge    = ~d_diff[WIDTH];
    assign d_rem   = d_ge ? d_diff[WIDTH-1:0] : d_shift[WIDTH-1:0];
    assign d_quo   = {qr[WIDTH-2:0], d_ge};

    assign last = (cnt == CNT_W'(WIDTH - 1));
    assign busy = (state == ST_MULT) || (state == ST_DIV);
    assign done = (state == ST_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (op == OP_MULT)
                        state_nxt = ST_MULT;
                    else if (b_in == '0)
                        state_nxt = ST_DONE;
                    else
                        state_nxt = ST_DIV;
                end
            end
            ST_MULT, ST_DIV: begin
                if (last)
                    state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            acc      <= '0;
            qr       <= '0;
            mr       <= '0;
            qm1      <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cnt      <= '0;
                        acc      <= '0;
                        qm1      <= 1'b0;
                        div_zero <= (op == OP_DIV) && (b_in == '0);
                        qr       <= (op == OP_MULT) ? b_in : abs_a;
                        mr       <= (op == OP_MULT) ? a_in : abs_b;
                        neg_r    <= a_in[WIDTH-1];
                        neg_q    <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
                    end
                end
                ST_MULT: begin
                    acc <= b_acc;
                    qr  <= b_q;
                    qm1 <= b_qm1;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        hi <= b_acc[WIDTH-1:0];
                        lo <= b_q;
                    end
                end
                ST_DIV: begin
                    acc <= {1'b0, d_rem};
                    qr  <= d_quo;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        lo <= neg_q ? -d_quo : d_quo;
                        hi <= neg_r ? -d_rem : d_rem;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table plus reset, divide-by-zero and stray-start sequences.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[10];

    mult_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Returns at the falling edge where done is seen (or after a 100-edge budget).
    task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                          output int edges, output int busy_cnt);
        @(negedge clk);
        start = 1'b1; op = o; a_in = a; b_in = b;
        @(posedge clk);
        edges = 1;
        busy_cnt = 0;
        @(negedge clk);
        start = 1'b0;
        while (!done && edges < 100) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    initial begin
        int edges, bcnt, pulses;
        bit seen;

        vecs[0] = '{1'b0, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1] = '{1'b0, 32'h80000000,  32'h80000000, 32'h40000000, 32'h00000000};
        vecs[2] = '{1'b1, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{1'b1, 32'd7,         32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[4] = '{1'b1, 32'h80000000,  32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5] = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[6] = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E};
        vecs[7] = '{1'b0, 32'h7FFFFFFF,  32'h80000000, 32'hC0000000, 32'h80000000};
        vecs[8] = '{1'b0, 32'd12345,     32'd0,        32'h00000000, 32'h00000000};
        vecs[9] = '{1'b1, 32'd3,         32'd5,        32'h00000003, 32'h00000000};

        #12;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_div_zero", div_zero, 0);
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, edges, bcnt);
            check($sformatf("v%0d_latency", i), edges, 33);
            check($sformatf("v%0d_busy_cycles", i), bcnt, 32);
            check($sformatf("v%0d_hi", i), hi, vecs[i].hi);
            check($sformatf("v%0d_lo", i), lo, vecs[i].lo);
            check($sformatf("v%0d_div_zero", i), div_zero, 0);
            @(negedge clk);
            check($sformatf("v%0d_done_one_cycle", i), done, 0);
        end

        // Divide by zero keeps HI/LO from the previous MULT and sets the sticky flag.
        run_op(1'b0, 32'd6, 32'd7, edges, bcnt);
        check("pre_dz_lo", lo, 42);
        run_op(1'b1, 32'd5, 32'd0, edges, bcnt);
        check("dz_latency", edges, 1);
        check("dz_busy_cycles", bcnt, 0);
        check("dz_flag", div_zero, 1);
        check("dz_hi_kept", hi, 0);
        check("dz_lo_kept", lo, 42);
        repeat (3) @(negedge clk);
        check("dz_flag_sticky", div_zero, 1);
        run_op(1'b0, 32'd2, 32'd3, edges, bcnt);
        check("post_dz_flag_cleared", div_zero, 0);
        check("post_dz_lo", lo, 6);
        check("post_dz_hi", hi, 0);

        // Asynchronous reset in the middle of a MULT.
        @(negedge clk);
        start = 1'b1; op = 1'b0; a_in = 32'h1234; b_in = 32'h5678;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        check("mid_busy_before_reset", busy, 1);
        reset = 1'b0;
        #1;
        check("mid_reset_busy", busy, 0);
        check("mid_reset_done", done, 0);
        check("mid_reset_hi", hi, 0);
        check("mid_reset_lo", lo, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset_idle", busy, 0);
        run_op(1'b1, 32'd100, 32'd7, edges, bcnt);
        check("post_reset_div_latency", edges, 33);
        check("post_reset_div_lo", lo, 14);
        check("post_reset_div_hi", hi, 2);

        // Stray starts while busy and while in DONE must be dropped.
        @(negedge clk);
        start = 1'b1; op = 1'b0; a_in = 32'd7; b_in = 32'hFFFFFFFD;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1; op = 1'b1; a_in = 32'd100; b_in = 32'd7;
        pulses = 0;
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                pulses++;
                if (!seen) begin
                    seen = 1'b1;
                    check("stray_first_hi", hi, 32'hFFFFFFFF);
                    check("stray_first_lo", lo, 32'hFFFFFFEB);
                    start = 1'b1; op = 1'b0; a_in = 32'd2; b_in = 32'd2;
                end
            end
        end
        check("stray_done_pulses", pulses, 1);
        check("stray_final_busy", busy, 0);
        check("stray_final_hi", hi, 32'hFFFFFFFF);
        check("stray_final_lo", lo, 32'hFFFFFFEB);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
